lshift_loader: RTL and testbench

Upstream feeder for the 8-bit left-rotate register `lshift_reg`. Accepts a byte and a rotate count over a valid/ready handshake, then drives `load_val`/`load_en` to load the register. It holds `load_en` low for exactly the requested number of rotate cycles, captures the register's `op` output, and returns it as a one-cycle result pulse. It sits between the command source and `lshift_reg`, and is the only driver of that register's load port.

---
 rtl/lshift_pkg.sv | 14 +
 rtl/lshift_reg.sv | 23 ++
 rtl/lshift_loader.sv | 71 +++++++
 tb/tb_lshift_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lshift_pkg.sv
// Shared constants and FSM state type for the lshift_reg loader.
// DW: data width, RW: rotate-count width, lshift_ld_state_t: FSM states.
package lshift_pkg;

  localparam int DW = 8;
  localparam int RW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ROT  = 2'd2
  } lshift_ld_state_t;

endpackage

// File: rtl/lshift_reg.sv
// 8-bit left-rotate register driven by lshift_loader.
// Ports: clk, rstn (sync, active-low), load_en, load_val in; op out.
module lshift_reg
  import lshift_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          load_en,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] op
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op <= '0;
    end else if (load_en) begin
      op <= load_val;
    end else begin
      op <= {op[DW-2:0], op[DW-1]};
    end
  end

endmodule

// File: rtl/lshift_loader.sv
// Loads a byte into lshift_reg, waits the requested rotate count, returns op.
// Ports: in_* command handshake, load_* to the register, op_in back, result_*.
module lshift_loader
  import lshift_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [RW-1:0] in_rot,
  output logic          in_ready,
  output logic [DW-1:0] load_val,
  output logic          load_en,
  input  logic [DW-1:0] op_in,
  output logic [DW-1:0] result_data,
  output logic          result_valid,
  output logic          busy
);

  lshift_ld_state_t state;
  logic [RW-1:0]    cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      in_ready     <= 1'b0;
      load_en      <= 1'b0;
      load_val     <= '0;
      result_data  <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            cnt      <= in_rot;
            load_val <= in_data;
            load_en  <= 1'b1;
            in_ready <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          load_en <= 1'b0;
          state   <= ROT;
        end
        ROT: begin
          // op_in already shows in_data rotated by (in_rot - cnt)
          if (cnt == '0) begin
            result_data  <= op_in;
            result_valid <= 1'b1;
            in_ready     <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          load_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lshift_loader.sv
// Directed bench for lshift_loader driving a real lshift_reg.
// Cycle model checks every output each cycle; literals pin key cases.
module tb_lshift_loader;
  import lshift_pkg::*;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rot;
  logic          in_ready;
  logic [DW-1:0] load_val;
  logic          load_en;
  logic [DW-1:0] op;
  logic [DW-1:0] result_data;
  logic          result_valid;
  logic          busy;

  lshift_loader dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_rot(in_rot),
    .in_ready(in_ready),
    .load_val(load_val), .load_en(load_en),
    .op_in(op),
    .result_data(result_data), .result_valid(result_valid),
    .busy(busy)
  );

  lshift_reg ureg (
    .clk(clk), .rstn(rstn),
    .load_en(load_en), .load_val(load_val), .op(op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] d, input int r);
    logic [15:0] w;
    w = {d, d} << r;
    return w[15:8];
  endfunction

  // Timeline model: cyc counts cycles; job events are cycle numbers.
  int          cyc = 0;
  bit          started = 0;
  logic        m_ready = 0;
  int          m_load = -1;
  int          m_done = -1;
  logic [7:0]  m_val = 0;
  logic [7:0]  m_res = 0;
  logic [7:0]  m_pend = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      started = 1;
      m_ready = 0;
      m_load  = -1;
      m_done  = -1;
      m_val   = 0;
      m_res   = 0;
    end else if (started) begin
      if (cyc == m_done) m_res = m_pend;
      if (m_ready && in_valid) begin
        m_ready = 0;
        m_load  = cyc;
        m_done  = cyc + 2 + int'(in_rot);
        m_val   = in_data;
        m_pend  = rotl(in_data, int'(in_rot));
      end else if (m_done < 0 || cyc >= m_done) begin
        m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("load_en", 32'(load_en), 32'(cyc == m_load));
      chk("busy", 32'(busy),
          32'(m_done >= 0 && cyc >= m_load && cyc < m_done));
      chk("result_valid", 32'(result_valid), 32'(cyc == m_done));
      chk("result_data", 32'(result_data), 32'(m_res));
      chk("load_val", 32'(load_val), 32'(m_val));
    end
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge; returns the acceptance cycle T.
  task automatic send(input logic [7:0] d, input logic [2:0] r,
                      input bit drop, output int t);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_rot   = r;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready 0 after %0d cycles", n);
    end
    t = cyc;
    @(negedge clk);
    if (drop) in_valid = 1'b0;
  endtask

  int t, t2;

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_rot   = 3'd3;
    // reset with in_valid held
    repeat (3) begin
      @(negedge clk);
      chk("rst_op", 32'(op), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h0);
      chk("rst_load_en", 32'(load_en), 32'h0);
    end
    rstn = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'h1);

    // basic
    send(8'h81, 3'd1, 1, t);
    chk("basic_load_t1", 32'(load_en), 32'h1);
    wait_to(t + 2);
    chk("basic_load_t2", 32'(load_en), 32'h0);
    wait_to(t + 4);
    chk("basic_rv", 32'(result_valid), 32'h1);
    chk("basic_rd", 32'(result_data), 32'h03);

    // zero rotate
    wait_to(t + 6);
    send(8'hA5, 3'd0, 1, t);
    chk("zero_busy1", 32'(busy), 32'h1);
    wait_to(t + 2);
    chk("zero_busy2", 32'(busy), 32'h1);
    wait_to(t + 3);
    chk("zero_busy3", 32'(busy), 32'h0);
    chk("zero_rv", 32'(result_valid), 32'h1);
    chk("zero_rd", 32'(result_data), 32'hA5);

    // max rotate, second command held while busy
    wait_to(t + 5);
    send(8'h01, 3'd7, 0, t);
    in_data = 8'h3C;
    in_rot  = 3'd2;
    wait_to(t + 9);
    chk("max_busy", 32'(busy), 32'h1);
    chk("max_ready", 32'(in_ready), 32'h0);
    wait_to(t + 10);
    chk("max_rv", 32'(result_valid), 32'h1);
    chk("max_rd", 32'(result_data), 32'h80);
    @(negedge clk);
    in_valid = 1'b0;
    wait_to(t + 15);
    chk("held_rv", 32'(result_valid), 32'h1);
    chk("held_rd", 32'(result_data), 32'hF0);

    // back-to-back in result_valid cycle
    wait_to(t + 17);
    send(8'h33, 3'd3, 1, t);
    wait_to(t + 6);
    chk("b2b_rd1", 32'(result_data), 32'h99);
    send(8'h0F, 3'd4, 1, t2);
    chk("b2b_t2", 32'(t2), 32'(t + 6));
    wait_to(t2 + 7);
    chk("b2b_rv2", 32'(result_valid), 32'h1);
    chk("b2b_rd2", 32'(result_data), 32'hF0);

    // reset mid-ROT
    wait_to(t2 + 9);
    send(8'h5A, 3'd6, 1, t);
    wait_to(t + 4);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_rd", 32'(result_data), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_lv", 32'(load_val), 32'h0);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    send(8'hC3, 3'd5, 1, t);
    wait_to(t + 8);
    chk("post_rv", 32'(result_valid), 32'h1);
    chk("post_rd", 32'(result_data), 32'h78);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
